// File: rtl/gating_pkg.sv
// Shared definitions for the gating sequencer and gating datapath.
// Mode encodings, sequencer state enum and default lane count.
package gating_pkg;

  localparam int LANES_DEF = 16;

  typedef enum logic [1:0] {
    MODE_ROUTER = 2'd0,
    MODE_NORM   = 2'd1,
    MODE_ACT    = 2'd2,
    MODE_AGG    = 2'd3
  } gate_mode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_XFER,
    S_ISSUE,
    S_FLUSH,
    S_WAIT_TOPK,
    S_DONE
  } seq_state_e;

  function automatic logic [11:0] sat_inc12(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

endpackage

// File: rtl/gating_seq_cnt.sv
// Lane, vector and element counters for the gating sequencer.
// elem_cnt saturates at 4095.
module gating_seq_cnt
  import gating_pkg::*;
#(
  parameter int LANES = LANES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        issue,
  input  logic        vec_inc,
  output logic        lane_last,
  output logic [7:0]  vec_cnt,
  output logic [11:0] elem_cnt
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  logic [LW-1:0] lane_cnt;

  assign lane_last = (lane_cnt == LW'(LANES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_cnt <= '0;
      vec_cnt  <= '0;
      elem_cnt <= '0;
    end else if (clr) begin
      lane_cnt <= '0;
      vec_cnt  <= '0;
      elem_cnt <= '0;
    end else begin
      if (issue) begin
        lane_cnt <= lane_last ? '0 : lane_cnt + 1'b1;
        elem_cnt <= sat_inc12(elem_cnt);
      end
      if (vec_inc)
        vec_cnt <= vec_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/gating_seq_ctrl.sv
// Gating sequencer: loads vectors, issues LANES elements each, flushes top-k.
// Optional WAIT_TOPK timeout enabled by GATING_SEQ_TIMEOUT_EN.
module gating_seq_ctrl
  import gating_pkg::*;
#(
  parameter int LANES   = LANES_DEF,
  parameter int TMO_CYC = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_mode,
  input  logic [2:0]   cmd_k,
  input  logic [7:0]   cmd_nvec,
  input  logic         vec_valid,
  output logic         vec_ready,
  input  logic [255:0] vec_data,
  output logic         g_in_valid,
  output logic [255:0] g_in_vec,
  output logic         g_cfg_valid,
  output logic [1:0]   g_cfg_mode,
  output logic [2:0]   g_cfg_k,
  output logic         g_cfg_topk_done,
  input  logic         g_topk_done,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [11:0]  elem_cnt
);

  seq_state_e state;
  logic [7:0] nvec_q;
  logic [7:0] vec_cnt;
  logic       lane_last;
  logic       issue;
  logic       last_vec;

  assign cmd_ready = (state == S_IDLE);
  assign vec_ready = (state == S_LOAD);
  assign issue     = (state == S_ISSUE);
  assign last_vec  = (vec_cnt == nvec_q);

  gating_seq_cnt #(.LANES(LANES)) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (cmd_ready && cmd_valid),
    .issue     (issue),
    .vec_inc   (issue && lane_last && !last_vec),
    .lane_last (lane_last),
    .vec_cnt   (vec_cnt),
    .elem_cnt  (elem_cnt)
  );

`ifdef GATING_SEQ_TIMEOUT_EN
  logic [8:0] tmo_cnt;
  logic       tmo_hit;

  assign tmo_hit = (tmo_cnt == 9'(TMO_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      err     <= 1'b0;
    end else begin
      err <= 1'b0;
      if (state != S_WAIT_TOPK)
        tmo_cnt <= '0;
      else if (!g_topk_done) begin
        if (tmo_hit)
          err <= 1'b1;
        else
          tmo_cnt <= tmo_cnt + 9'd1;
      end
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^9'(TMO_CYC);
  assign err = 1'b0;
`endif

  // Outputs are registered alongside the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      nvec_q          <= '0;
      g_cfg_mode      <= '0;
      g_cfg_k         <= '0;
      g_in_vec        <= '0;
      g_in_valid      <= 1'b0;
      g_cfg_valid     <= 1'b0;
      g_cfg_topk_done <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      g_in_valid      <= 1'b0;
      g_cfg_topk_done <= 1'b0;
      done            <= 1'b0;
      unique case (state)
        S_IDLE: if (cmd_valid) begin
          g_cfg_mode <= cmd_mode;
          g_cfg_k    <= cmd_k;
          nvec_q     <= cmd_nvec;
          busy       <= 1'b1;
          state      <= S_LOAD;
        end
        S_LOAD: if (vec_valid) begin
          g_in_vec   <= vec_data;
          g_in_valid <= 1'b1;
          state      <= S_XFER;
        end
        S_XFER: begin
          g_cfg_valid <= 1'b1;
          state       <= S_ISSUE;
        end
        S_ISSUE: if (lane_last) begin
          g_cfg_valid <= 1'b0;
          if (!last_vec)
            state <= S_LOAD;
          else if (g_cfg_mode == MODE_ROUTER) begin
            g_cfg_topk_done <= 1'b1;
            state           <= S_FLUSH;
          end else begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_FLUSH: state <= S_WAIT_TOPK;
        S_WAIT_TOPK: begin
          if (g_topk_done) begin
            done  <= 1'b1;
            state <= S_DONE;
          end
`ifdef GATING_SEQ_TIMEOUT_EN
          else if (tmo_hit) begin
            done  <= 1'b1;
            state <= S_DONE;
          end
`endif
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gating_seq_ctrl.sv
// Scoreboard bench for gating_seq_ctrl with randomized commands.
// Timeout behaviour checked when GATING_SEQ_TIMEOUT_EN is defined.
module tb_gating_seq_ctrl;

  localparam int LANES = 16;
  localparam int TMO   = 20;

  logic         clk, rst_n;
  logic         cmd_valid, cmd_ready;
  logic [1:0]   cmd_mode;
  logic [2:0]   cmd_k;
  logic [7:0]   cmd_nvec;
  logic         vec_valid, vec_ready;
  logic [255:0] vec_data;
  logic         g_in_valid;
  logic [255:0] g_in_vec;
  logic         g_cfg_valid;
  logic [1:0]   g_cfg_mode;
  logic [2:0]   g_cfg_k;
  logic         g_cfg_topk_done;
  logic         g_topk_done;
  logic         busy, done, err;
  logic [11:0]  elem_cnt;

  gating_seq_ctrl #(.LANES(LANES), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_k(cmd_k), .cmd_nvec(cmd_nvec),
    .vec_valid(vec_valid), .vec_ready(vec_ready),
    .vec_data(vec_data),
    .g_in_valid(g_in_valid), .g_in_vec(g_in_vec),
    .g_cfg_valid(g_cfg_valid), .g_cfg_mode(g_cfg_mode),
    .g_cfg_k(g_cfg_k), .g_cfg_topk_done(g_cfg_topk_done),
    .g_topk_done(g_topk_done),
    .busy(busy), .done(done), .err(err),
    .elem_cnt(elem_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic [2:0] k;
    int         nvec;
    bit         err;
  } exp_t;

  exp_t         exp_q[$];
  logic [255:0] vec_q[$];

  int total = 0, bad = 0, cyc = 0;
  int issues = 0, loads = 0, topks = 0;
  int last_issue = 0, flush_cyc = 0;
  int topk_in_cyc = 0, done_cyc = 0;
  int ndone = 0;
  bit prev_done = 0;
  int topk_delay = 5;
  int cd = 0;
  int spur_req = 0, spur_ack = 0;
  bit tmo_exp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [255:0] act,
                       input logic [255:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin : mon
    exp_t e;
    int   en;
    if (!rst_n) begin
      exp_q.delete();
      vec_q.delete();
      issues = 0; loads = 0; topks = 0;
      prev_done = 0;
    end else begin
      if (prev_done)
        check("post_done_idle", {done, busy, cmd_ready}, 3'b001);
      prev_done = done;
      if (g_in_valid) begin
        loads++;
        if (vec_q.size() == 0) check("vec_unexpected", 1, 0);
        else check("g_in_vec", g_in_vec, vec_q.pop_front());
      end
      if (g_cfg_valid) begin
        issues++;
        last_issue = cyc;
        if (exp_q.size() == 0) check("issue_unexpected", 1, 0);
        else check("cfg_mode_k",
                   {g_cfg_mode, g_cfg_k, cmd_ready, vec_ready, busy},
                   {exp_q[0].mode, exp_q[0].k, 3'b001});
      end
      if (g_cfg_topk_done) begin
        topks++;
        flush_cyc = cyc;
      end
      if (g_topk_done) topk_in_cyc = cyc;
      if (done) begin
        ndone++;
        done_cyc = cyc;
        if (exp_q.size() == 0) check("done_unexpected", 1, 0);
        else begin
          e  = exp_q.pop_front();
          en = (e.nvec + 1) * LANES;
          check("elem_cnt", elem_cnt, (en > 4095) ? 4095 : en);
          check("issues", issues, en);
          check("loads", loads, e.nvec + 1);
          check("topk_pulses", topks, (e.mode == 2'd0) ? 1 : 0);
          check("err", err, e.err);
          check("cfg_at_done", {busy, g_cfg_mode, g_cfg_k},
                {1'b1, e.mode, e.k});
          if (e.err)
            check("tmo_latency", cyc - flush_cyc, TMO + 1);
          else if (e.mode == 2'd0)
            check("topk_latency", cyc - topk_in_cyc, 1);
          else
            check("done_latency", cyc - last_issue, 1);
        end
        issues = 0; loads = 0; topks = 0;
      end
    end
  end

  // Top-k responder plus spurious-pulse injector.
  initial begin
    g_topk_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      g_topk_done = 1'b0;
      if (spur_req != spur_ack) begin
        g_topk_done = 1'b1;
        spur_ack = spur_req;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) g_topk_done = 1'b1;
      end
      if (rst_n && g_cfg_topk_done && topk_delay > 0)
        cd = topk_delay;
    end
  end

  task automatic send_cmd(input logic [1:0] m, input logic [2:0] k,
                          input logic [7:0] n, input bit follow);
    int   t;
    exp_t e;
    @(negedge clk);
    cmd_mode = m; cmd_k = k; cmd_nvec = n;
    cmd_valid = 1'b1;
    t = 0;
    while (!cmd_ready && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check("cmd_accept", cmd_ready, 1);
    if (cmd_ready) begin
      e.mode = m; e.k = k; e.nvec = int'(n); e.err = tmo_exp;
      exp_q.push_back(e);
      if (follow) check("accept_after_done", cyc - done_cyc, 1);
      @(posedge clk);
    end
    #1;
    cmd_valid = 1'b0;
    cmd_mode = 2'($urandom); cmd_k = 3'($urandom);
    cmd_nvec = 8'($urandom);
  endtask

  task automatic feed(input int n, input int gmin, input int gmax,
                      input bit fixed);
    logic [255:0] v;
    int t, g;
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (i > 0) begin
        t = 0;
        while (!vec_ready && t < 1000) begin
          @(negedge clk);
          t++;
        end
      end
      g = $urandom_range(gmax, gmin);
      for (int j = 0; j < g; j++) @(negedge clk);
      if (g > 0 && i > 0)
        check("load_stall", {vec_ready, g_cfg_valid}, 2'b10);
      for (int w = 0; w < 8; w++) v[w*32 +: 32] = $urandom;
      if (fixed) v = {16{16'h3C00}};
      vec_q.push_back(v);
      vec_data  = v;
      vec_valid = 1'b1;
      t = 0;
      while (!vec_ready && t < 1000) begin
        @(negedge clk);
        t++;
      end
      if (!vec_ready) check("vec_accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      vec_valid = 1'b0;
      vec_data  = {8{$urandom}};
    end
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (ndone < target && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check("done_reached", (ndone >= target) ? 1 : 0, 1);
    @(negedge clk);
  endtask

  initial begin : main
    int nd, t;
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_mode = '0; cmd_k = '0; cmd_nvec = '0;
    vec_valid = 1'b0; vec_data = '0;
    repeat (3) @(negedge clk);
    check("reset_ctrl",
          {cmd_ready, vec_ready, busy, done, err,
           g_in_valid, g_cfg_valid, g_cfg_topk_done},
          8'b1000_0000);
    check("reset_data", {g_in_vec, g_cfg_mode, g_cfg_k, elem_cnt}, 0);
    rst_n = 1'b1;

    nd = ndone;
    send_cmd(2'd2, 3'd0, 8'd0, 0);
    feed(0, 0, 0, 1);
    wait_done(nd + 1);

    nd = ndone;
    topk_delay = 5;
    send_cmd(2'd0, 3'd7, 8'd3, 0);
    feed(3, 0, 2, 0);
    wait_done(nd + 1);

    nd = ndone;
    send_cmd(2'd3, 3'd2, 8'd1, 0);
    feed(1, 10, 10, 0);
    wait_done(nd + 1);

    nd = ndone;
    topk_delay = 3;
    send_cmd(2'd0, 3'd3, 8'd1, 0);
    fork
      feed(1, 0, 1, 0);
      begin
        t = 0;
        while (!g_cfg_valid && t < 200) begin
          @(negedge clk);
          t++;
        end
        repeat (3) @(negedge clk);
        spur_req++;
      end
      send_cmd(2'd2, 3'd5, 8'd0, 1);
    join
    feed(0, 0, 1, 0);
    wait_done(nd + 2);

    repeat (6) begin
      nd = ndone;
      topk_delay = $urandom_range(6, 1);
      send_cmd(2'($urandom), 3'($urandom),
               8'($urandom_range(3, 0)), 0);
      feed(int'(exp_q[0].nvec), 0, 3, 0);
      wait_done(nd + 1);
    end

    nd = ndone;
    send_cmd(2'd1, 3'd1, 8'd255, 0);
    feed(255, 0, 0, 0);
    wait_done(nd + 1);

    send_cmd(2'd2, 3'd4, 8'd0, 0);
    feed(0, 0, 0, 0);
    t = 0;
    while (issues < 8 && t < 200) begin
      @(negedge clk);
      #2;
      t++;
    end
    rst_n = 1'b0;
    #1;
    check("mid_issue_reset",
          {cmd_ready, vec_ready, busy, g_cfg_valid, done},
          5'b10000);
    check("mid_issue_elem", elem_cnt, 0);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;

    topk_delay = -1;
`ifdef GATING_SEQ_TIMEOUT_EN
    tmo_exp = 1;
    nd = ndone;
    send_cmd(2'd0, 3'd1, 8'd0, 0);
    feed(0, 0, 0, 0);
    wait_done(nd + 1);
    tmo_exp = 0;
`else
    send_cmd(2'd0, 3'd1, 8'd0, 0);
    feed(0, 0, 0, 0);
    repeat (80) @(negedge clk);
    check("wait_topk_hold", {busy, done, err}, 3'b100);
    #2;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
`endif
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
